rtc_reg_bank: RTL and testbench

- Parametrised successor to the single-level RTC capture register set.
- Captures bytes from the RTC data bus into a shadow bank. Writes are addressed either directly by a register select or by an auto-incrementing burst pointer.
- The shadow bank is copied atomically to the visible bank on commit, so display/timer logic never sees a half-updated time.
- Adds per-register dirty and BCD-error flags and select-error reporting.

---
 rtl/rtc_reg_bank.sv | 94 +++++++++
 tb/tb_rtc_reg_bank.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rtc_reg_bank.sv
// rtc_reg_bank: RTC capture shadow bank with direct/burst addressing, atomic commit to a visible bank,
// dirty/BCD-error flags and select-error pulses.
module rtc_reg_bank #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 9,
  parameter int SEL_W     = 4,
  parameter int BASE_SEL  = 1,
  parameter int CHECK_BCD = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         LL_signal,
  input  logic [DATA_W-1:0]            dato_rtc,
  input  logic [SEL_W-1:0]             reg_select,
  input  logic                         burst_mode,
  input  logic                         burst_start,
  input  logic                         commit,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          dirty_mask,
  output logic [NUM_REGS-1:0]          bcd_err_mask,
  output logic                         burst_busy,
  output logic                         burst_done,
  output logic                         commit_done,
  output logic                         sel_err
);
  localparam int PW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] BASE = BASE_SEL;
  localparam logic [31:0] NREG = NUM_REGS;
  localparam logic [PW-1:0] LAST = PW'(NUM_REGS - 1);
  typedef enum logic [1:0] {IDLE, ARMED, AUTO} state_t;
  state_t state, state_next;
  logic [PW-1:0] ptr;
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] visible [NUM_REGS];
  logic [31:0] sel, idx;
  logic direct_ok, burst_wr, wr_en, do_commit, auto, bcd_bad;
  always_comb begin
    sel = 32'(reg_select);
    direct_ok = sel >= BASE && sel - BASE < NREG;
    burst_wr = LL_signal && burst_mode && state == ARMED;
    wr_en = burst_wr || (LL_signal && !burst_mode && direct_ok);
    idx = burst_mode ? 32'(ptr) : sel - BASE;
    do_commit = commit || auto;
  end
  always_comb begin
    bcd_bad = 1'b0;
    for (int n = 0; n < DATA_W / 4; n++) bcd_bad |= CHECK_BCD != 0 && dato_rtc[4*n +: 4] > 4'd9;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = burst_start ? ARMED : IDLE;
      ARMED:   state_next = !burst_start && burst_wr && ptr == LAST ? AUTO : ARMED;
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
    burst_busy = state == ARMED;
    auto = state == AUTO;
  end
  // A write and a commit on the same edge: visible takes the pre-edge shadow and the dirty set wins.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= '0;
      dirty_mask <= '0;
      bcd_err_mask <= '0;
      burst_done <= 1'b0;
      commit_done <= 1'b0;
      sel_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        visible[i] <= '0;
      end
    end else begin
      ptr <= burst_start && !auto ? '0 : burst_wr ? (ptr == LAST ? '0 : ptr + PW'(1)) : ptr;
      burst_done <= auto;
      commit_done <= do_commit;
      sel_err <= LL_signal && !wr_en;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (do_commit) visible[i] <= shadow[i];
        if (wr_en && idx == 32'(i)) begin
          shadow[i] <= dato_rtc;
          dirty_mask[i] <= 1'b1;
          bcd_err_mask[i] <= bcd_bad;
        end else if (do_commit) dirty_mask[i] <= 1'b0;
      end
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign regs_out[i*DATA_W +: DATA_W] = visible[i];
  end
endmodule

// File: tb/tb_rtc_reg_bank.sv
// tb_rtc_reg_bank: directed plus randomized stimulus checked against an array-based reference model.
module tb_rtc_reg_bank;
  logic clk = 0, reset = 1, ll = 0, bm = 0, bs = 0, cm = 0;
  logic [7:0] dato = 0;
  logic [3:0] sel = 0;
  logic [71:0] regs_out;
  logic [8:0] dirty_mask, bcd_err_mask;
  logic burst_busy, burst_done, commit_done, sel_err;
  int checks = 0, errors = 0;

  rtc_reg_bank dut (
    .clk(clk), .reset(reset), .LL_signal(ll), .dato_rtc(dato), .reg_select(sel),
    .burst_mode(bm), .burst_start(bs), .commit(cm), .regs_out(regs_out),
    .dirty_mask(dirty_mask), .bcd_err_mask(bcd_err_mask), .burst_busy(burst_busy),
    .burst_done(burst_done), .commit_done(commit_done), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // reference model: plain arrays, mode 0 idle / 1 armed / 2 auto-commit
  logic [7:0] m_shadow [9];
  logic [7:0] m_visible [9];
  bit m_dirty [9];
  bit m_bcd [9];
  int m_mode, m_ptr;
  bit e_bdone, e_cdone, e_serr;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_shadow[i] = 0; m_visible[i] = 0; m_dirty[i] = 0; m_bcd[i] = 0;
    end
    m_mode = 0; m_ptr = 0; e_bdone = 0; e_cdone = 0; e_serr = 0;
  endtask

  task automatic model_step();
    int tgt;
    bit do_c;
    tgt = -1;
    do_c = cm || m_mode == 2;
    e_serr = 0;
    if (ll) begin
      if (!bm) begin
        if (int'(sel) - 1 >= 0 && int'(sel) - 1 < 9) tgt = int'(sel) - 1; else e_serr = 1;
      end else if (m_mode == 1) tgt = m_ptr;
      else e_serr = 1;
    end
    e_cdone = do_c;
    e_bdone = m_mode == 2;
    if (do_c) for (int i = 0; i < 9; i++) begin m_visible[i] = m_shadow[i]; m_dirty[i] = 0; end
    if (tgt >= 0) begin
      m_shadow[tgt] = dato; m_dirty[tgt] = 1;
      m_bcd[tgt] = dato[7:4] > 9 || dato[3:0] > 9;
    end
    if (m_mode == 0) begin
      if (bs) begin m_mode = 1; m_ptr = 0; end
    end else if (m_mode == 1) begin
      if (bs) m_ptr = 0;
      else if (ll && bm) begin
        if (m_ptr == 8) begin m_mode = 2; m_ptr = 0; end else m_ptr++;
      end
    end else m_mode = 0;
  endtask

  task automatic compare_all(input string tag);
    logic [71:0] v;
    logic [8:0] d, b;
    for (int i = 0; i < 9; i++) begin
      v[i*8 +: 8] = m_visible[i]; d[i] = m_dirty[i]; b[i] = m_bcd[i];
    end
    chk({tag, ".regs"}, regs_out, v);
    chk({tag, ".dirty"}, dirty_mask, d);
    chk({tag, ".bcd"}, bcd_err_mask, b);
    chk({tag, ".busy"}, burst_busy, m_mode == 1);
    chk({tag, ".bdone"}, burst_done, e_bdone);
    chk({tag, ".cdone"}, commit_done, e_cdone);
    chk({tag, ".serr"}, sel_err, e_serr);
  endtask

  task automatic op(input string tag, input bit l, input bit b, input logic [3:0] s,
                    input logic [7:0] d, input bit st, input bit c);
    ll = l; bm = b; sel = s; dato = d; bs = st; cm = c;
    model_step();
    @(posedge clk); #1;
    compare_all(tag);
    ll = 0; bs = 0; cm = 0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    #1;
    model_reset();
    compare_all(tag);
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    model_reset();
    #1;
    compare_all("por");
    @(posedge clk); #1;
    reset = 0;
    // 1: direct write then commit
    op("t1w", 1, 0, 1, 8'h45, 0, 0);
    op("t1c", 0, 0, 0, 0, 0, 1);
    op("t1i", 0, 0, 0, 0, 0, 0);
    // 2: uncommitted write and out-of-range selects
    op("t2w", 1, 0, 3, 8'h12, 0, 0);
    op("t2s0", 1, 0, 0, 8'h99, 0, 0);
    op("t2i", 0, 0, 0, 0, 0, 0);
    op("t2s10", 1, 0, 10, 8'h99, 0, 0);
    op("t2i2", 0, 0, 0, 0, 0, 0);
    // 3: full burst with auto-commit
    op("t3s", 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) op("t3w", 1, 1, 0, 8'(i + 1), 0, 0);
    op("t3a", 0, 0, 0, 0, 0, 0);
    op("t3i", 0, 0, 0, 0, 0, 0);
    // 4: BCD flag set then cleared
    op("t4a", 1, 0, 5, 8'h5A, 0, 0);
    op("t4b", 1, 0, 5, 8'h31, 0, 0);
    op("t4c", 0, 0, 0, 0, 0, 1);
    // 5: commit coincident with write
    op("t5a", 1, 0, 2, 8'h20, 0, 1);
    op("t5b", 1, 0, 2, 8'h77, 0, 1);
    op("t5c", 0, 0, 0, 0, 0, 0);
    op("t5d", 0, 0, 0, 0, 0, 1);
    // 6: reset mid-burst
    op("t6s", 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) op("t6w", 1, 1, 0, 8'h50 + 8'(i), 0, 0);
    do_reset("t6r");
    op("t6x", 1, 1, 0, 8'h11, 0, 0);
    op("t6i", 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] d;
      d = $urandom_range(0, 1) ? {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))} : 8'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset("rrst");
      else op("rnd", $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 11)), d,
              $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
